// File: rtl/rect_fill_engine.sv
// Rectangle-fill pixel source: clips a command rectangle to the framebuffer and
// streams one framebuffer write per cycle, row-major, with a stall hold.
module rect_fill_engine #(
    parameter int FB_W   = 1280,
    parameter int FB_H   = 720,
    parameter int X_W    = 11,
    parameter int Y_W    = 10,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [X_W-1:0]    cmd_x_i,
    input  logic [Y_W-1:0]    cmd_y_i,
    input  logic [X_W-1:0]    cmd_w_i,
    input  logic [Y_W-1:0]    cmd_h_i,
    input  logic [DATA_W-1:0] cmd_color_i,
    input  logic              pxl_stall_i,
    output logic [ADDR_W-1:0] pxl_addr_o,
    output logic [DATA_W-1:0] pxl_data_o,
    output logic              pxl_en_o,
    output logic              busy_o,
    output logic              done_o
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FILL, S_DONE} state_t;

    localparam logic [X_W:0]      FB_W_X = (X_W+1)'(FB_W);
    localparam logic [Y_W:0]      FB_H_Y = (Y_W+1)'(FB_H);
    localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);

    state_t r_state;
    state_t w_state_next;

    logic [X_W-1:0]    r_x, r_w, r_cw, r_col;
    logic [Y_W-1:0]    r_y, r_h, r_ch, r_row;
    logic [DATA_W-1:0] r_color;
    logic [ADDR_W-1:0] r_row_base;

    logic [ADDR_W-1:0] r_pxl_addr;
    logic [DATA_W-1:0] r_pxl_data;
    logic              r_pxl_en, r_cmd_ready, r_busy, r_done;

    logic              w_accept, w_empty, w_col_last, w_row_last;
    logic [X_W:0]      w_x_ext, w_w_ext, w_room_x, w_cw_ext;
    logic [Y_W:0]      w_y_ext, w_h_ext, w_room_y, w_ch_ext;
    logic [ADDR_W-1:0] w_base;

    assign w_accept = cmd_valid_i & r_cmd_ready;

    // Clip at one extra bit so x+w / y+h never wrap before comparison.
    assign w_x_ext  = {1'b0, r_x};
    assign w_w_ext  = {1'b0, r_w};
    assign w_y_ext  = {1'b0, r_y};
    assign w_h_ext  = {1'b0, r_h};
    assign w_room_x = FB_W_X - w_x_ext;
    assign w_room_y = FB_H_Y - w_y_ext;
    assign w_cw_ext = (w_w_ext < w_room_x) ? w_w_ext : w_room_x;
    assign w_ch_ext = (w_h_ext < w_room_y) ? w_h_ext : w_room_y;
    assign w_empty  = (w_x_ext >= FB_W_X) | (w_y_ext >= FB_H_Y) |
                      (r_w == '0) | (r_h == '0);
    assign w_base   = ADDR_W'(r_y) * FB_W_A;

    assign w_col_last = (r_col == r_cw - X_W'(1));
    assign w_row_last = (r_row == r_ch - Y_W'(1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_SETUP;
            S_SETUP: w_state_next = w_empty ? S_DONE : S_FILL;
            S_FILL:  if (!pxl_stall_i && w_col_last && w_row_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // The output registers always hold the pixel currently presented; the
    // counters (r_col, r_row) index that same pixel.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_x <= '0; r_y <= '0; r_w <= '0; r_h <= '0; r_color <= '0;
            r_cw <= '0; r_ch <= '0; r_col <= '0; r_row <= '0;
            r_row_base <= '0;
            r_pxl_addr <= '0; r_pxl_data <= '0; r_pxl_en <= 1'b0;
            r_cmd_ready <= 1'b1; r_busy <= 1'b0; r_done <= 1'b0;
        end else begin
            r_cmd_ready <= (w_state_next == S_IDLE);
            r_busy      <= (w_state_next != S_IDLE);
            r_done      <= (w_state_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    r_pxl_en <= 1'b0;
                    if (w_accept) begin
                        r_x     <= cmd_x_i;
                        r_y     <= cmd_y_i;
                        r_w     <= cmd_w_i;
                        r_h     <= cmd_h_i;
                        r_color <= cmd_color_i;
                    end
                end
                S_SETUP: begin
                    r_cw       <= w_cw_ext[X_W-1:0];
                    r_ch       <= w_ch_ext[Y_W-1:0];
                    r_col      <= '0;
                    r_row      <= '0;
                    r_row_base <= w_base;
                    if (!w_empty) begin
                        r_pxl_en   <= 1'b1;
                        r_pxl_addr <= w_base + ADDR_W'(r_x);
                        r_pxl_data <= r_color;
                    end
                end
                S_FILL: begin
                    if (pxl_stall_i) begin
                        r_pxl_en <= 1'b0;
                    end else if (w_col_last) begin
                        if (w_row_last) begin
                            r_pxl_en <= 1'b0;
                        end else begin
                            r_col      <= '0;
                            r_row      <= r_row + Y_W'(1);
                            r_row_base <= r_row_base + FB_W_A;
                            r_pxl_addr <= r_row_base + FB_W_A + ADDR_W'(r_x);
                            r_pxl_en   <= 1'b1;
                        end
                    end else begin
                        r_col      <= r_col + X_W'(1);
                        r_pxl_addr <= r_pxl_addr + ADDR_W'(1);
                        r_pxl_en   <= 1'b1;
                    end
                end
                default: r_pxl_en <= 1'b0;
            endcase
        end
    end

    assign cmd_ready_o = r_cmd_ready;
    assign pxl_addr_o  = r_pxl_addr;
    assign pxl_data_o  = r_pxl_data;
    assign pxl_en_o    = r_pxl_en;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: logs every write strobe and done pulse
// with its cycle number, then checks them against hand-computed expectations.
module tb_rect_fill_engine;
    localparam int FB_W = 1280, FB_H = 720, X_W = 11, Y_W = 10;
    localparam int DATA_W = 16, ADDR_W = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [X_W-1:0]    cmd_x = '0, cmd_w = '0;
    logic [Y_W-1:0]    cmd_y = '0, cmd_h = '0;
    logic [DATA_W-1:0] cmd_color = '0;
    logic              pxl_stall = 1'b0;
    logic [ADDR_W-1:0] pxl_addr;
    logic [DATA_W-1:0] pxl_data;
    logic              pxl_en, busy, done;

    rect_fill_engine #(.FB_W(FB_W), .FB_H(FB_H), .X_W(X_W), .Y_W(Y_W),
                       .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_x_i(cmd_x), .cmd_y_i(cmd_y), .cmd_w_i(cmd_w), .cmd_h_i(cmd_h),
        .cmd_color_i(cmd_color), .pxl_stall_i(pxl_stall),
        .pxl_addr_o(pxl_addr), .pxl_data_o(pxl_data), .pxl_en_o(pxl_en),
        .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ev_cyc[$], ev_addr[$], ev_data[$], dn_cyc[$];
    int exp_addr[$], exp_off[$], exp_data[$], exp_done[$];
    int n_tests = 0, n_fail = 0;

    always @(negedge clk) begin
        if (pxl_en) begin
            ev_cyc.push_back(cyc);
            ev_addr.push_back(int'(pxl_addr));
            ev_data.push_back(int'(pxl_data));
        end
        if (done) dn_cyc.push_back(cyc);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        ev_cyc.delete(); ev_addr.delete(); ev_data.delete(); dn_cyc.delete();
        exp_addr.delete(); exp_off.delete(); exp_data.delete(); exp_done.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_cmd(input int x, input int y, input int w, input int h, input int c);
        cmd_x = x[X_W-1:0]; cmd_y = y[Y_W-1:0];
        cmd_w = w[X_W-1:0]; cmd_h = h[Y_W-1:0];
        cmd_color = c[DATA_W-1:0];
    endtask

    // Waits (bounded) for ready with valid already high; returns the accept cycle.
    task automatic wait_accept(input string tag, output int acc);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " accept"}, int'(cmd_ready), 1);
        acc = cyc;
    endtask

    task automatic send(input string tag, input int x, input int y, input int w,
                        input int h, input int c, output int acc);
        @(negedge clk);
        drive_cmd(x, y, w, h, c);
        cmd_valid = 1'b1;
        wait_accept(tag, acc);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic set_data(input int d);
        exp_data.delete();
        foreach (exp_addr[i]) exp_data.push_back(d);
    endtask

    task automatic set_offsets_linear(input int first);
        exp_off.delete();
        foreach (exp_addr[i]) exp_off.push_back(first + i);
    endtask

    task automatic check_run(input string tag, input int acc);
        int n;
        chk($sformatf("%s pixel count", tag), ev_addr.size(), exp_addr.size());
        n = (ev_addr.size() < exp_addr.size()) ? ev_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s addr[%0d]", tag, i), ev_addr[i], exp_addr[i]);
            chk($sformatf("%s cycle[%0d]", tag, i), ev_cyc[i] - acc, exp_off[i]);
            chk($sformatf("%s data[%0d]", tag, i), ev_data[i], exp_data[i]);
        end
        chk($sformatf("%s done count", tag), dn_cyc.size(), exp_done.size());
        n = (dn_cyc.size() < exp_done.size()) ? dn_cyc.size() : exp_done.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s done cycle[%0d]", tag, i), dn_cyc[i] - acc, exp_done[i]);
    endtask

    initial begin
        int acc, acc_b;

        // Reset state
        idle(3);
        chk("rst ready", int'(cmd_ready), 1);
        chk("rst en", int'(pxl_en), 0);
        chk("rst addr", int'(pxl_addr), 0);
        chk("rst data", int'(pxl_data), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        rst = 1'b0;
        idle(2);

        // Small rect (10,5,3,2)
        clear_logs();
        send("small", 10, 5, 3, 2, 'h07E0, acc);
        chk("small ready low", int'(cmd_ready), 0);
        chk("small busy", int'(busy), 1);
        idle(12);
        exp_addr = '{6410, 6411, 6412, 7690, 7691, 7692};
        set_offsets_linear(2); set_data('h07E0);
        exp_done = '{8};
        check_run("small", acc);
        chk("small ready after", int'(cmd_ready), 1);

        // Bottom-right corner clip
        clear_logs();
        send("corner", 1278, 719, 10, 10, 'h001F, acc);
        idle(8);
        exp_addr = '{921598, 921599};
        set_offsets_linear(2); set_data('h001F);
        exp_done = '{4};
        check_run("corner", acc);

        // Right-edge clip with row wrap
        clear_logs();
        send("rclip", 1277, 0, 5, 2, 'h0A0A, acc);
        idle(12);
        exp_addr = '{1277, 1278, 1279, 2557, 2558, 2559};
        set_offsets_linear(2); set_data('h0A0A);
        exp_done = '{8};
        check_run("rclip", acc);

        // Empty commands: x off-screen, y off-screen, zero width, zero height
        clear_logs();
        send("xoff", 1280, 0, 4, 4, 'h1111, acc);
        idle(6);
        exp_done = '{2};
        check_run("xoff", acc);
        clear_logs();
        send("yoff", 0, 720, 1, 1, 'h2222, acc);
        idle(6);
        exp_done = '{2};
        check_run("yoff", acc);
        clear_logs();
        send("w0", 5, 5, 0, 3, 'h3333, acc);
        idle(6);
        exp_done = '{2};
        check_run("w0", acc);
        clear_logs();
        send("h0", 5, 5, 3, 0, 'h4444, acc);
        idle(6);
        exp_done = '{2};
        check_run("h0", acc);

        // Stall for 3 cycles after the second pixel
        clear_logs();
        send("stall", 0, 0, 4, 1, 'hFFFF, acc);
        idle(2);
        pxl_stall = 1'b1;
        idle(1);
        chk("stall en low", int'(pxl_en), 0);
        chk("stall addr held", int'(pxl_addr), 1);
        idle(2);
        pxl_stall = 1'b0;
        idle(8);
        exp_addr = '{0, 1, 2, 3};
        exp_off  = '{2, 3, 7, 8};
        set_data('hFFFF);
        exp_done = '{9};
        check_run("stall", acc);

        // Reset mid-fill abandons the rectangle
        clear_logs();
        send("midrst", 0, 0, 4, 4, 'h00FF, acc);
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("midrst en", int'(pxl_en), 0);
        chk("midrst ready", int'(cmd_ready), 1);
        chk("midrst busy", int'(busy), 0);
        idle(20);
        chk("midrst pixels", ev_addr.size(), 2);
        chk("midrst done count", dn_cyc.size(), 0);
        clear_logs();
        send("postrst", 0, 0, 1, 1, 'h1234, acc);
        idle(6);
        exp_addr = '{0};
        set_offsets_linear(2); set_data('h1234);
        exp_done = '{3};
        check_run("postrst", acc);

        // Back-to-back with valid held high
        clear_logs();
        @(negedge clk);
        drive_cmd(4, 2, 2, 1, 'hAAAA);
        cmd_valid = 1'b1;
        wait_accept("b2b A", acc);
        @(negedge clk);
        drive_cmd(100, 3, 2, 1, 'hBBBB);
        chk("b2b ready low", int'(cmd_ready), 0);
        wait_accept("b2b B", acc_b);
        chk("b2b gap", acc_b - acc, 5);
        @(negedge clk);
        cmd_valid = 1'b0;
        idle(10);
        exp_addr = '{2564, 2565, 3940, 3941};
        exp_off  = '{2, 3, 7, 8};
        exp_data = '{'hAAAA, 'hAAAA, 'hBBBB, 'hBBBB};
        exp_done = '{4, 9};
        check_run("b2b", acc);

        // Full-width fill clipped at the bottom edge (2 rows of 1280)
        clear_logs();
        send("wide", 0, 718, 1280, 5, 'h5555, acc);
        idle(2600);
        for (int i = 0; i < 2560; i++) exp_addr.push_back(919040 + i);
        set_offsets_linear(2); set_data('h5555);
        exp_done = '{2562};
        check_run("wide", acc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
